// File: rtl/vpu_dispatch_pkg.sv
// Shared types and constants for the VPU dispatch controller.
//   state_e      : dispatch FSM state encoding
//   DATA_W       : default vector register / RO width
//   NUM_VEC      : default number of vector operand registers
//   RO_ABORT_VAL : RO value written back when the watchdog aborts an op
//   LAT_SAT      : saturation value of the last_latency register
package vpu_dispatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StRun   = 2'd2,
    StWb    = 2'd3
  } state_e;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned NUM_VEC      = 8;
  localparam logic [15:0] RO_ABORT_VAL = 16'hFFFF;
  localparam logic [15:0] LAT_SAT      = 16'hFFFF;

endpackage

// File: rtl/vpu_watchdog.sv
// Cycle counter for the RUN phase of a VPU operation.
//   clk, rst : clock and synchronous active-high reset
//   clr      : force the count to zero (has priority over en)
//   en       : advance the count by one (saturates at all-ones)
//   count    : current count
//   expire   : count has reached TIMEOUT-1; never asserted when TIMEOUT is 0
module vpu_watchdog #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = (TIMEOUT != 0) && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/vpu_dispatch_ctrl.sv
// Sequences one VPU operation per VPU-class instruction in decode/execute:
// snapshot operands, request/ack handshake, wait for done (with watchdog),
// then a single-cycle RO writeback strobe to the register file.
//   clk, rst     : clock and synchronous active-high reset
//   start        : VPU instruction present in DEX (level)
//   vec_in       : packed V7..V0 from the register file (V0 in the low bits)
//   vpu_ack      : VPU accepted the request
//   vpu_done     : VPU result valid (1-cycle pulse), with vpu_ro
//   stall        : combinational pipeline stall request
//   vpu_req      : registered request to the VPU (high throughout ISSUE)
//   vpu_abort    : registered 1-cycle pulse on watchdog expiry
//   vec_out      : operand snapshot driven to the VPU
//   rf_we_vpu    : registered 1-cycle RO write enable (high in WB)
//   ro_out       : RO data to the register file
//   err_timeout  : sticky watchdog error, cleared only by rst
//   last_latency : ack-to-done cycles of the last completed op (saturating)
module vpu_dispatch_ctrl #(
  parameter int unsigned DATA_W  = vpu_dispatch_pkg::DATA_W,
  parameter int unsigned NUM_VEC = vpu_dispatch_pkg::NUM_VEC,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_VEC*DATA_W-1:0] vec_in,
  input  logic                      vpu_ack,
  input  logic                      vpu_done,
  input  logic [DATA_W-1:0]         vpu_ro,
  output logic                      stall,
  output logic                      vpu_req,
  output logic                      vpu_abort,
  output logic [NUM_VEC*DATA_W-1:0] vec_out,
  output logic                      rf_we_vpu,
  output logic [DATA_W-1:0]         ro_out,
  output logic                      err_timeout,
  output logic [15:0]               last_latency
);
  import vpu_dispatch_pkg::*;

  // With the watchdog disabled the counter still feeds last_latency, so give
  // it the full latency width instead of a degenerate one.
  localparam int unsigned CntW = (TIMEOUT == 0) ? 16 : $clog2(TIMEOUT + 1);

  state_e                      state_q, state_d;
  logic [NUM_VEC*DATA_W-1:0]   vec_q, vec_d;
  logic [DATA_W-1:0]           ro_q, ro_d;
  logic [15:0]                 lat_q, lat_d;
  logic                        req_q, req_d;
  logic                        abort_q, abort_d;
  logic                        we_q, we_d;
  logic                        err_q, err_d;

  logic                        wd_clr, wd_en, wd_expire;
  logic [CntW-1:0]             wd_count;
  logic [32:0]                 lat_inc;

  vpu_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CntW)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .count  (wd_count),
    .expire (wd_expire)
  );

  // Done in RUN reports count+1 cycles since ack.
  assign lat_inc = 33'(wd_count) + 33'd1;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ro_d    = ro_q;
    lat_d   = lat_q;
    err_d   = err_q;
    abort_d = 1'b0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    stall   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          stall   = 1'b1;
          vec_d   = vec_in;
          state_d = StIssue;
        end
      end
      StIssue: begin
        stall  = 1'b1;
        wd_clr = 1'b1;
        if (vpu_ack) begin
          if (vpu_done) begin
            ro_d    = vpu_ro;
            lat_d   = '0;
            state_d = StWb;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        stall = 1'b1;
        wd_en = 1'b1;
        // Done takes priority over a same-cycle expiry.
        if (vpu_done) begin
          ro_d    = vpu_ro;
          lat_d   = (lat_inc > 33'(LAT_SAT)) ? LAT_SAT : lat_inc[15:0];
          state_d = StWb;
        end else if (wd_expire) begin
          ro_d    = DATA_W'(RO_ABORT_VAL);
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = StWb;
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    req_d = (state_d == StIssue);
    we_d  = (state_d == StWb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      ro_q    <= '0;
      lat_q   <= '0;
      req_q   <= 1'b0;
      abort_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      ro_q    <= ro_d;
      lat_q   <= lat_d;
      req_q   <= req_d;
      abort_q <= abort_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign vpu_req      = req_q;
  assign vpu_abort    = abort_q;
  assign vec_out      = vec_q;
  assign rf_we_vpu    = we_q;
  assign ro_out       = ro_q;
  assign err_timeout  = err_q;
  assign last_latency = lat_q;

endmodule

// File: tb/tb_vpu_dispatch_ctrl.sv
// Directed bench for vpu_dispatch_ctrl with TIMEOUT=8.
module tb_vpu_dispatch_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] vec_in;
  logic         vpu_ack;
  logic         vpu_done;
  logic [15:0]  vpu_ro;
  logic         stall;
  logic         vpu_req;
  logic         vpu_abort;
  logic [127:0] vec_out;
  logic         rf_we_vpu;
  logic [15:0]  ro_out;
  logic         err_timeout;
  logic [15:0]  last_latency;

  int vec_count  = 0;
  int miscompares = 0;
  int we_cnt     = 0;
  int we_base;

  logic [127:0] vec_a;
  logic [127:0] vec_b;

  vpu_dispatch_ctrl #(
    .DATA_W  (16),
    .NUM_VEC (8),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vec_in       (vec_in),
    .vpu_ack      (vpu_ack),
    .vpu_done     (vpu_done),
    .vpu_ro       (vpu_ro),
    .stall        (stall),
    .vpu_req      (vpu_req),
    .vpu_abort    (vpu_abort),
    .vec_out      (vec_out),
    .rf_we_vpu    (rf_we_vpu),
    .ro_out       (ro_out),
    .err_timeout  (err_timeout),
    .last_latency (last_latency)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rf_we_vpu is high for a whole cycle, so one negedge sample per pulse.
  always @(negedge clk) if (rf_we_vpu === 1'b1) we_cnt++;

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_count++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vec_a[i*16 +: 16] = 16'(i + 1);
      vec_b[i*16 +: 16] = 16'hAAA0 + 16'(i);
    end
    rst = 1'b1; start = 1'b0; vec_in = '0;
    vpu_ack = 1'b0; vpu_done = 1'b0; vpu_ro = '0;
    tk(); tk();
    rst = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", vpu_req, 0);
    chk("rst_abort", vpu_abort, 0);
    chk("rst_we", rf_we_vpu, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_vec", vec_out, 0);
    chk("rst_ro", ro_out, 0);
    chk("rst_lat", last_latency, 0);

    // Nominal: one ISSUE cycle without ack, ack, 5 RUN cycles, done.
    we_base = we_cnt;
    vec_in = vec_a; start = 1'b1;
    #1 chk("nom_stall_idle", stall, 1);
    tk();                                   // ISSUE, no ack yet
    start = 1'b0; vec_in = 128'h5555;
    #1;
    chk("nom_vec_cap", vec_out, vec_a);
    chk("nom_req", vpu_req, 1);
    chk("nom_stall_issue", stall, 1);
    tk();                                   // still ISSUE
    chk("nom_req_wait", vpu_req, 1);
    vpu_ack = 1'b1;
    tk();                                   // RUN cycle 1
    vpu_ack = 1'b0;
    chk("nom_req_run", vpu_req, 0);
    for (int i = 0; i < 4; i++) begin
      chk("nom_stall_run", stall, 1);
      chk("nom_we_run", rf_we_vpu, 0);
      tk();
    end
    vpu_done = 1'b1; vpu_ro = 16'hBEEF;     // RUN cycle 5
    chk("nom_stall_run5", stall, 1);
    tk();                                   // WB
    vpu_done = 1'b0;
    #1;
    chk("nom_we", rf_we_vpu, 1);
    chk("nom_ro", ro_out, 16'hBEEF);
    chk("nom_lat", last_latency, 5);
    chk("nom_stall_wb", stall, 0);
    chk("nom_abort", vpu_abort, 0);
    chk("nom_vec_hold", vec_out, vec_a);
    tk();                                   // IDLE
    chk("nom_we_off", rf_we_vpu, 0);
    chk("nom_we_count", we_cnt - we_base, 1);

    // Fast path: ack and done together in ISSUE.
    start = 1'b1;
    tk();                                   // ISSUE
    start = 1'b0; vpu_ack = 1'b1; vpu_done = 1'b1; vpu_ro = 16'h1234;
    #1 chk("fast_we_early", rf_we_vpu, 0);
    tk();                                   // WB, 2 cycles after start
    vpu_ack = 1'b0; vpu_done = 1'b0;
    chk("fast_we", rf_we_vpu, 1);
    chk("fast_ro", ro_out, 16'h1234);
    chk("fast_lat", last_latency, 0);
    tk();

    // Watchdog: ack, then no done; expiry on the 8th RUN cycle.
    start = 1'b1;
    tk();                                   // ISSUE
    start = 1'b0; vpu_ack = 1'b1;
    tk();                                   // RUN cycle 1
    vpu_ack = 1'b0;
    for (int i = 0; i < 7; i++) tk();       // RUN cycle 8
    chk("wd_abort_early", vpu_abort, 0);
    chk("wd_stall_run8", stall, 1);
    tk();                                   // WB
    chk("wd_abort", vpu_abort, 1);
    chk("wd_ro", ro_out, 16'hFFFF);
    chk("wd_err", err_timeout, 1);
    chk("wd_we", rf_we_vpu, 1);
    chk("wd_lat_kept", last_latency, 0);
    tk();                                   // IDLE
    chk("wd_abort_pulse", vpu_abort, 0);
    tk(); tk();
    chk("wd_err_sticky", err_timeout, 1);
    rst = 1'b1;
    tk();
    rst = 1'b0;
    chk("wd_err_clr", err_timeout, 0);
    chk("wd_ro_clr", ro_out, 0);

    // Done/expiry race: done on the 8th RUN cycle wins.
    start = 1'b1;
    tk();
    start = 1'b0; vpu_ack = 1'b1;
    tk();                                   // RUN cycle 1
    vpu_ack = 1'b0;
    for (int i = 0; i < 7; i++) tk();       // RUN cycle 8
    vpu_done = 1'b1; vpu_ro = 16'h5A5A;
    tk();                                   // WB
    vpu_done = 1'b0;
    chk("race_ro", ro_out, 16'h5A5A);
    chk("race_abort", vpu_abort, 0);
    chk("race_err", err_timeout, 0);
    chk("race_lat", last_latency, 8);
    chk("race_we", rf_we_vpu, 1);
    tk();

    // Reset mid-RUN.
    we_base = we_cnt;
    start = 1'b1;
    tk();
    start = 1'b0; vpu_ack = 1'b1;
    tk();                                   // RUN cycle 1
    vpu_ack = 1'b0;
    tk();                                   // RUN cycle 2
    rst = 1'b1;
    tk();
    rst = 1'b0;
    chk("mrst_stall", stall, 0);
    chk("mrst_req", vpu_req, 0);
    chk("mrst_we", rf_we_vpu, 0);
    vpu_done = 1'b1; vpu_ro = 16'h7777;
    tk();
    vpu_done = 1'b0;
    chk("mrst_done_we", rf_we_vpu, 0);
    chk("mrst_done_ro", ro_out, 0);
    chk("mrst_done_stall", stall, 0);
    tk();
    chk("mrst_we_count", we_cnt - we_base, 0);

    // Back-to-back: start held high across both operations.
    we_base = we_cnt;
    vec_in = vec_a; start = 1'b1;
    tk();                                   // op1 ISSUE
    vpu_ack = 1'b1; vpu_done = 1'b1; vpu_ro = 16'h0101;
    #1 chk("b2b_stall_issue1", stall, 1);
    tk();                                   // op1 WB
    vpu_ack = 1'b0; vpu_done = 1'b0; vec_in = vec_b;
    #1;
    chk("b2b_stall_wb1", stall, 0);
    chk("b2b_vec1", vec_out, vec_a);
    chk("b2b_ro1", ro_out, 16'h0101);
    tk();                                   // IDLE, start still high
    chk("b2b_stall_idle", stall, 1);
    tk();                                   // op2 ISSUE
    start = 1'b0; vpu_ack = 1'b1;
    #1;
    chk("b2b_vec2", vec_out, vec_b);
    chk("b2b_stall_issue2", stall, 1);
    tk();                                   // op2 RUN cycle 1
    vpu_ack = 1'b0; vpu_done = 1'b1; vpu_ro = 16'h0202;
    #1 chk("b2b_stall_run", stall, 1);
    tk();                                   // op2 WB
    vpu_done = 1'b0;
    chk("b2b_stall_wb2", stall, 0);
    chk("b2b_ro2", ro_out, 16'h0202);
    chk("b2b_lat2", last_latency, 1);
    tk();
    chk("b2b_we_count", we_cnt - we_base, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/vpu_dispatch_ctrl.md
Name: vpu_dispatch_ctrl

Overview:
- Sequences one VPU operation per VPU-class instruction sitting in decode/execute.
- On start it snapshots the eight vector-operand registers V0-V7, then handshakes the request to the VPU and holds the CPU pipeline stalled until the VPU finishes.
- It then issues a single-cycle return-object (RO) writeback strobe to the register file.
- A watchdog aborts hung VPU operations. The block replaces ad-hoc VPU_rdy stall logic in the control unit.

Parameters:
- DATA_W, 16, width of each vector register and of the RO.
- NUM_VEC, 8, number of vector operand registers (V0..V7).
- TIMEOUT, 1023, maximum RUN cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  control unit decodes a VPU instruction in DEX; level signal.
- vec_in  in  NUM_VEC*DATA_W  packed V7..V0 read from the register file (V0 = bits [15:0]).
- vpu_ack  in  1  VPU accepted the request.
- vpu_done  in  1  VPU result valid; 1-cycle pulse.
- vpu_ro  in  DATA_W  VPU return object; valid with vpu_done.
- stall  out  1  pipeline stall request to the CPU; combinational.
- vpu_req  out  1  request to the VPU; registered.
- vpu_abort  out  1  1-cycle pulse on watchdog expiry; registered.
- vec_out  out  NUM_VEC*DATA_W  latched operand snapshot driven to the VPU.
- rf_we_vpu  out  1  RO write enable to the register file; registered, 1 cycle.
- ro_out  out  DATA_W  RO data to the register file; valid while rf_we_vpu=1.
- err_timeout  out  1  sticky watchdog flag; cleared only by rst.
- last_latency  out  16  ack-to-done cycle count of the last completed op; saturates at 16'hFFFF.

Behaviour:
- Reset: rst=1 at a clock edge forces state IDLE and clears every register. vpu_req, vpu_abort, rf_we_vpu, err_timeout = 0; vec_out, ro_out, last_latency = 0; counter = 0. A reset mid-operation drops vpu_req on the same edge and suppresses any pending writeback.
- States: IDLE, ISSUE, RUN, WB.
- stall = (IDLE & start) | ISSUE | RUN. stall is 0 in WB, so the VPU instruction retires in the WB cycle.
- IDLE:
  - start=1: capture vec_in into vec_out and go to ISSUE.
  - start=0: stay in IDLE. vpu_ack and vpu_done are ignored.
- ISSUE: vpu_req=1.
  - vpu_ack=1 and vpu_done=0: go to RUN and clear the counter.
  - vpu_ack=1 and vpu_done=1 in the same cycle: latch vpu_ro and go directly to WB; last_latency=0.
  - vpu_ack=0: stay in ISSUE. The watchdog does not count in ISSUE.
- RUN: vpu_req=0; the counter increments each cycle.
  - vpu_done=1: latch ro_out=vpu_ro and last_latency=counter+1 (saturating); go to WB.
  - Watchdog: TIMEOUT!=0 and counter==TIMEOUT-1 with vpu_done=0: ro_out=16'hFFFF, vpu_abort=1 for one cycle, err_timeout=1; go to WB.
  - vpu_done and expiry in the same cycle: done wins; no abort, no error.
- WB: rf_we_vpu=1 for exactly one cycle; next state IDLE unconditionally.
- Back-to-back VPU instructions: start=1 seen in IDLE the cycle after WB is a new operation. Minimum issue interval is 3 cycles (IDLE, ISSUE, WB).
- vec_out holds its value from capture until the next capture. It is stable throughout ISSUE/RUN/WB.
- Latency from a start rising into IDLE to rf_we_vpu:
  - ack-same-cycle-as-done: 2 cycles.
  - otherwise: 3 + (cycles waiting for ack) + (RUN cycles - 1).

Decomposition:
- Package vpu_dispatch_pkg holds:
  - state enum {IDLE, ISSUE, RUN, WB} as 2-bit encoding;
  - localparams DATA_W=16, NUM_VEC=8;
  - RO_ABORT_VAL=16'hFFFF;
  - LAT_SAT=16'hFFFF.
- One sub-module, vpu_watchdog, contains:
  - the counter of width $clog2(TIMEOUT+1);
  - inputs clr, en;
  - output expire, asserted when count==TIMEOUT-1 and TIMEOUT!=0.
- The FSM, snapshot register and RO/latency registers stay in vpu_dispatch_ctrl.

Test Plan:
- Nominal op:
  - Stimulus: vec_in = V0..V7 = 16'h0001..16'h0008; start=1; ack after 2 cycles; done after 5 RUN cycles with vpu_ro=16'hBEEF.
  - Required: stall high from the start cycle through RUN; vec_out matches the captured values; rf_we_vpu pulses once with ro_out=16'hBEEF; last_latency=5.
- Fast path:
  - Stimulus: vpu_ack and vpu_done in the same ISSUE cycle, vpu_ro=16'h1234.
  - Required: RUN skipped; rf_we_vpu 2 cycles after start; last_latency=0.
- Watchdog:
  - Stimulus: TIMEOUT=8; ack, then no done.
  - Required: after 8 RUN cycles vpu_abort pulses; ro_out=16'hFFFF; err_timeout stays 1 until rst.
- Done/expiry race:
  - Stimulus: TIMEOUT=8; done arrives on the 8th RUN cycle.
  - Required: ro_out=vpu_ro, vpu_abort=0, err_timeout=0.
- Reset mid-RUN:
  - Stimulus: assert rst for 1 cycle while in RUN.
  - Required: next cycle state IDLE, vpu_req=0, stall=0, no rf_we_vpu; a later done pulse is ignored.
- Back-to-back:
  - Stimulus: two VPU instructions; vec_in changes to 16'hAAAA.. between them.
  - Required: the second capture reflects the new values; exactly two rf_we_vpu pulses; stall low only in each WB cycle.
